// File: rtl/dmem_ctrl_if.sv
// Data-memory request/response bundle between the datapath and dmem_ctrl.
// DMEM_PERF_CNT_EN adds the load/store performance counter outputs.
interface dmem_ctrl_if;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [31:0] addr_i32;
    logic [31:0] write_data_i32;
    logic [31:0] read_data_o32;
    logic        stall_o;
    logic        misalign_o;
    logic        busy_o;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] rd_count_o32;
    logic [31:0] wr_count_o32;
`endif

    modport master (
        output mem_read_i, mem_write_i, addr_i32, write_data_i32,
`ifdef DMEM_PERF_CNT_EN
        input  rd_count_o32, wr_count_o32,
`endif
        input  read_data_o32, stall_o, misalign_o, busy_o
    );

    modport slave (
        input  mem_read_i, mem_write_i, addr_i32, write_data_i32,
`ifdef DMEM_PERF_CNT_EN
        output rd_count_o32, wr_count_o32,
`endif
        output read_data_o32, stall_o, misalign_o, busy_o
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Fixed-latency data memory with stall, misalignment suppression and wrap.
// DMEM_PERF_CNT_EN enables the completed-load/store counters.
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic         clk_i,
    input  logic         reset_i,
    dmem_ctrl_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam bit NO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_INIT =
        NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic [AW-1:0]  lat_idx;
    logic [31:0]    lat_data;
    logic           lat_wr;

    logic [31:0]    mem [DEPTH_WORDS];

    logic           req;
    logic           mis;
    logic           act;
    logic           done;
    logic           stall;
    logic           wr;
    logic [AW-1:0]  idx;
    logic [31:0]    wdat;

    assign req = bus.mem_read_i | bus.mem_write_i;
    assign mis = req & (bus.addr_i32[1:0] != 2'b00);
    assign act = req & ~mis & ~reset_i;

    // In WAIT the latched request owns the RAM; live inputs are ignored.
    always_comb begin
        idx   = bus.addr_i32[AW+1:2];
        wdat  = bus.write_data_i32;
        wr    = bus.mem_write_i;
        done  = 1'b0;
        stall = 1'b0;
        if (state == IDLE) begin
            done  = act & NO_WAIT;
            stall = act & ~NO_WAIT;
        end else begin
            idx   = lat_idx;
            wdat  = lat_data;
            wr    = lat_wr;
            done  = (cnt == 4'd0) & ~reset_i;
            stall = (cnt != 4'd0) & ~reset_i;
        end
    end

    assign bus.stall_o       = stall;
    assign bus.misalign_o    = mis & ~reset_i;
    assign bus.busy_o        = (state == WAIT);
    assign bus.read_data_o32 = done ? mem[idx] : 32'd0;

    always_ff @(posedge clk_i) begin
        if (done && wr)
            mem[idx] <= wdat;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            lat_idx  <= '0;
            lat_data <= 32'd0;
            lat_wr   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (act && !NO_WAIT) begin
                        lat_idx  <= bus.addr_i32[AW+1:2];
                        lat_data <= bus.write_data_i32;
                        lat_wr   <= bus.mem_write_i;
                        cnt      <= CNT_INIT;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_cnt <= 32'd0;
            wr_cnt <= 32'd0;
        end else if (done) begin
            if (wr)
                wr_cnt <= wr_cnt + 32'd1;
            else
                rd_cnt <= rd_cnt + 32'd1;
        end
    end

    assign bus.rd_count_o32 = rd_cnt;
    assign bus.wr_count_o32 = wr_cnt;
`endif
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: dut_a uses 2 wait states, dut_b uses none.
module tb_dmem_ctrl;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    dmem_ctrl_if ia ();
    dmem_ctrl_if ib ();

    dmem_ctrl #(.DEPTH_WORDS(64), .WAIT_STATES(2)) dut_a (
        .clk_i(clk), .reset_i(rst), .bus(ia.slave));
    dmem_ctrl #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut_b (
        .clk_i(clk), .reset_i(rst), .bus(ib.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_a(input logic rd, input logic wr,
                         input logic [31:0] ad, input logic [31:0] d);
        ia.mem_read_i     = rd;
        ia.mem_write_i    = wr;
        ia.addr_i32       = ad;
        ia.write_data_i32 = d;
        #1;
    endtask

    task automatic set_b(input logic rd, input logic wr,
                         input logic [31:0] ad, input logic [31:0] d);
        ib.mem_read_i     = rd;
        ib.mem_write_i    = wr;
        ib.addr_i32       = ad;
        ib.write_data_i32 = d;
        #1;
    endtask

    // Full 3-cycle access on dut_a with no checking, used to preload words.
    task automatic op_a(input logic wr, input logic [31:0] ad,
                        input logic [31:0] d);
        set_a(~wr, wr, ad, d);
        cyc();
        cyc();
        cyc();
        set_a(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_a(1'b0, 1'b0, 32'd0, 32'd0);
        set_b(1'b0, 1'b0, 32'd0, 32'd0);
        cyc();
        n_chk++;
        if ({ia.stall_o, ia.busy_o, ia.misalign_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_a_flags got=%b exp=000",
                     {ia.stall_o, ia.busy_o, ia.misalign_o});
        end
        n_chk++;
        if (ia.read_data_o32 !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_a_rd got=%h exp=0", ia.read_data_o32);
        end
        n_chk++;
        if ({ib.stall_o, ib.busy_o, ib.read_data_o32} !== 34'd0) begin
            n_fail++;
            $display("FAIL rst_b got=%h exp=0",
                     {ib.stall_o, ib.busy_o, ib.read_data_o32});
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_wait_store_load();
        set_a(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        n_chk++;
        if ({ia.stall_o, ia.busy_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL st_c0 got=%b exp=10", {ia.stall_o, ia.busy_o});
        end
        cyc();
        n_chk++;
        if ({ia.stall_o, ia.busy_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL st_c1 got=%b exp=11", {ia.stall_o, ia.busy_o});
        end
        cyc();
        n_chk++;
        if ({ia.stall_o, ia.busy_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL st_c2 got=%b exp=01", {ia.stall_o, ia.busy_o});
        end
        cyc();
        set_a(1'b1, 1'b0, 32'h10, 32'h0);
        n_chk++;
        if ({ia.stall_o, ia.busy_o, ia.read_data_o32} !== {2'b10, 32'h0}) begin
            n_fail++;
            $display("FAIL ld_c0 got=%h exp=%h",
                     {ia.stall_o, ia.busy_o, ia.read_data_o32}, {2'b10, 32'h0});
        end
        cyc();
        n_chk++;
        if (ia.read_data_o32 !== 32'h0) begin
            n_fail++;
            $display("FAIL ld_c1 got=%h exp=0", ia.read_data_o32);
        end
        cyc();
        n_chk++;
        if ({ia.stall_o, ia.read_data_o32} !== {1'b0, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL ld_c2 got=%h exp=%h",
                     {ia.stall_o, ia.read_data_o32}, {1'b0, 32'hDEADBEEF});
        end
        cyc();
        set_a(1'b0, 1'b0, 32'd0, 32'd0);
        n_chk++;
        if ({ia.stall_o, ia.busy_o, ia.read_data_o32} !== 34'd0) begin
            n_fail++;
            $display("FAIL idle_a got=%h exp=0",
                     {ia.stall_o, ia.busy_o, ia.read_data_o32});
        end
    endtask

    task automatic test_back_to_back();
        set_b(1'b0, 1'b1, 32'h0, 32'h11111111);
        n_chk++;
        if (ib.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_st0 got=%b exp=0", ib.stall_o);
        end
        cyc();
        set_b(1'b0, 1'b1, 32'h4, 32'h22222222);
        n_chk++;
        if ({ib.stall_o, ib.busy_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_st4 got=%b exp=00", {ib.stall_o, ib.busy_o});
        end
        cyc();
        set_b(1'b1, 1'b0, 32'h0, 32'h0);
        n_chk++;
        if ({ib.stall_o, ib.read_data_o32} !== {1'b0, 32'h11111111}) begin
            n_fail++;
            $display("FAIL b2b_ld0 got=%h exp=%h",
                     {ib.stall_o, ib.read_data_o32}, {1'b0, 32'h11111111});
        end
        cyc();
        set_b(1'b1, 1'b0, 32'h4, 32'h0);
        n_chk++;
        if (ib.read_data_o32 !== 32'h22222222) begin
            n_fail++;
            $display("FAIL b2b_ld4 got=%h exp=22222222", ib.read_data_o32);
        end
        cyc();
        set_b(1'b1, 1'b1, 32'h4, 32'h33333333);
        n_chk++;
        if (ib.read_data_o32 !== 32'h22222222) begin
            n_fail++;
            $display("FAIL rdwr_pre got=%h exp=22222222", ib.read_data_o32);
        end
        cyc();
        set_b(1'b1, 1'b0, 32'h4, 32'h0);
        n_chk++;
        if (ib.read_data_o32 !== 32'h33333333) begin
            n_fail++;
            $display("FAIL rdwr_post got=%h exp=33333333", ib.read_data_o32);
        end
        cyc();
        set_b(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_misalign();
        op_a(1'b1, 32'h20, 32'h0A0A0A0A);
        set_a(1'b1, 1'b0, 32'h13, 32'h0);
        n_chk++;
        if ({ia.misalign_o, ia.stall_o, ia.read_data_o32} !== {2'b10, 32'h0}) begin
            n_fail++;
            $display("FAIL mis_ld got=%h exp=%h",
                     {ia.misalign_o, ia.stall_o, ia.read_data_o32}, {2'b10, 32'h0});
        end
        cyc();
        n_chk++;
        if (ia.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_busy got=%b exp=0", ia.busy_o);
        end
        set_a(1'b0, 1'b1, 32'h22, 32'hBADBAD00);
        n_chk++;
        if ({ia.misalign_o, ia.stall_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL mis_st got=%b exp=10", {ia.misalign_o, ia.stall_o});
        end
        cyc();
        set_a(1'b0, 1'b0, 32'h0, 32'h0);
        n_chk++;
        if (ia.misalign_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_clr got=%b exp=0", ia.misalign_o);
        end
        set_a(1'b1, 1'b0, 32'h20, 32'h0);
        cyc();
        cyc();
        n_chk++;
        if (ia.read_data_o32 !== 32'h0A0A0A0A) begin
            n_fail++;
            $display("FAIL mis_word8 got=%h exp=0a0a0a0a", ia.read_data_o32);
        end
        cyc();
        set_a(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_wrap();
        op_a(1'b1, 32'h100, 32'h12345678);
        set_a(1'b1, 1'b0, 32'h0, 32'h0);
        cyc();
        cyc();
        n_chk++;
        if (ia.read_data_o32 !== 32'h12345678) begin
            n_fail++;
            $display("FAIL wrap got=%h exp=12345678", ia.read_data_o32);
        end
        cyc();
        set_a(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid();
        op_a(1'b1, 32'h8, 32'h55AA55AA);
        set_a(1'b0, 1'b1, 32'h8, 32'hCAFEF00D);
        cyc();
        n_chk++;
        if ({ia.stall_o, ia.busy_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL rm_wait got=%b exp=11", {ia.stall_o, ia.busy_o});
        end
        rst = 1'b1;
        set_a(1'b0, 1'b0, 32'h0, 32'h0);
        n_chk++;
        if ({ia.stall_o, ia.busy_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL rm_async got=%b exp=00", {ia.stall_o, ia.busy_o});
        end
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        set_a(1'b1, 1'b0, 32'h8, 32'h0);
        cyc();
        cyc();
        n_chk++;
        if (ia.read_data_o32 !== 32'h55AA55AA) begin
            n_fail++;
            $display("FAIL rm_old got=%h exp=55aa55aa", ia.read_data_o32);
        end
        cyc();
        set_a(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

`ifdef DMEM_PERF_CNT_EN
    task automatic test_perf();
        rst = 1'b1;
        #1;
        cyc();
        rst = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) op_a(1'b0, 32'(i * 4), 32'h0);
        for (int i = 0; i < 2; i++) op_a(1'b1, 32'h40, 32'(i));
        set_a(1'b0, 1'b1, 32'h41, 32'h0);
        cyc();
        set_a(1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        n_chk++;
        if (ia.rd_count_o32 !== 32'd3) begin
            n_fail++;
            $display("FAIL perf_rd got=%0d exp=3", ia.rd_count_o32);
        end
        n_chk++;
        if (ia.wr_count_o32 !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_wr got=%0d exp=2", ia.wr_count_o32);
        end
    endtask
`endif

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        @(negedge clk);
        test_reset();
        test_wait_store_load();
        test_back_to_back();
        test_misalign();
        test_wrap();
        test_reset_mid();
`ifdef DMEM_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
